// File: rtl/write_sched_pkg.sv
// Shared definitions for the vector data-memory write scheduler.
//   state_t  : controller states (IDLE, WRITE, DONE)
//   req_id_t : requester id (0 = execute-stage store unit, 1 = loader)
//   I_DEF/L_DEF/A_DEF : default items per vector, item width, address width
package write_sched_pkg;

    localparam int I_DEF = 20;
    localparam int L_DEF = 32;
    localparam int A_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
//   req   : request bits from the two requesters
//   prio  : requester that wins when both request at once
//   grant : one-hot grant, or zero when nobody requests
// The priority pointer itself is owned and updated by the caller.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/write_scheduler.sv
// Arbitrates two requesters onto one memory write port and sequences
// scalar (one word) or vector (I consecutive words) stores.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake; a request is taken in the
//                       cycle where valid and ready are both high. ready is
//                       only raised in IDLE, for at most one requester, and a
//                       requester must hold valid and operands until then.
//   req_op_type       : 1 = vector store, 0 = scalar store
//   req_base_address, req_vector_data, req_scalar_data : per-requester operands
//   mem_we/address/data : one write per WRITE cycle; address/data are 0 when idle
//   busy              : controller not in IDLE
//   done, done_id     : one-cycle completion pulse and the completed requester
//   state             : current controller state, for observation
module write_scheduler
    import write_sched_pkg::*;
#(
    parameter int I = I_DEF,
    parameter int L = L_DEF,
    parameter int A = A_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_op_type,
    input  logic [1:0][A-1:0]      req_base_address,
    input  logic [1:0][I-1:0][L-1:0] req_vector_data,
    input  logic [1:0][L-1:0]      req_scalar_data,
    output logic                   mem_we,
    output logic [A-1:0]           mem_address,
    output logic [L-1:0]           mem_data,
    output logic                   busy,
    output logic                   done,
    output logic                   done_id,
    output state_t                 state
);

    localparam int IW = (I > 1) ? $clog2(I) : 1;
    localparam logic [IW-1:0] LAST = IW'(I - 1);

    state_t              state_q, state_d;
    logic [1:0]          grant;
    logic                prio_q;
    req_id_t             winner;
    req_id_t             id_q;
    logic                accept;

    logic                op_q;
    logic [A-1:0]        base_q;
    logic [I-1:0][L-1:0] vec_q;
    logic [L-1:0]        sc_q;
    logic [IW-1:0]       index_q;

    rr_arbiter2 u_arb (
        .req   (req_valid),
        .prio  (prio_q),
        .grant (grant)
    );

    assign winner = grant[1];

    // Ready is suppressed while reset is asserted so that reset always wins
    // over a same-cycle acceptance.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE && !rst) begin
            req_ready = grant;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WRITE;
            WRITE:   if (!op_q || index_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            index_q <= '0;
            id_q    <= 1'b0;
            op_q    <= 1'b0;
            base_q  <= '0;
            vec_q   <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= req_op_type[winner];
                base_q  <= req_base_address[winner];
                vec_q   <= req_vector_data[winner];
                sc_q    <= req_scalar_data[winner];
                id_q    <= winner;
                index_q <= '0;
                prio_q  <= ~winner;
            end else if (state_q == WRITE && op_q && index_q != LAST) begin
                index_q <= index_q + 1'b1;
            end
        end
    end

    // Memory outputs decode only from registered state; the A-bit sum wraps
    // naturally past the top of the address space.
    always_comb begin
        mem_we      = (state_q == WRITE);
        mem_address = '0;
        mem_data    = '0;
        if (mem_we) begin
            mem_address = base_q + A'(index_q);
            mem_data    = op_q ? vec_q[index_q] : sc_q;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = done ? id_q : 1'b0;
    assign state   = state_q;

endmodule

// File: tb/tb_write_scheduler.sv
module tb_write_scheduler;
    import write_sched_pkg::*;

    localparam int I = 20;
    localparam int L = 32;
    localparam int A = 10;

    typedef struct packed {
        logic                op;
        logic                abort;
        logic [A-1:0]        base;
        logic [I-1:0][L-1:0] vec;
        logic [L-1:0]        sc;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [1:0]              req_op_type;
    logic [1:0][A-1:0]       req_base_address;
    logic [1:0][I-1:0][L-1:0] req_vector_data;
    logic [1:0][L-1:0]       req_scalar_data;
    logic                    mem_we;
    logic [A-1:0]            mem_address;
    logic [L-1:0]            mem_data;
    logic                    busy;
    logic                    done;
    logic                    done_id;
    state_t                  state;

    write_scheduler #(.I(I), .L(L), .A(A)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op_type      (req_op_type),
        .req_base_address (req_base_address),
        .req_vector_data  (req_vector_data),
        .req_scalar_data  (req_scalar_data),
        .mem_we           (mem_we),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .busy             (busy),
        .done             (done),
        .done_id          (done_id),
        .state            (state)
    );

    // ---------------- scoreboard / reference model ----------------
    int vectors = 0;
    int miscompares = 0;

    logic [A+L-1:0] exp_q[$];
    int             exp_cyc_q[$];
    int             done_cyc_q[$];
    logic           done_id_q[$];

    int   cyc = 0;
    int   free_at = 0;     // first cycle a new request may be accepted
    int   busy_from = 0;   // first cycle of the current busy window
    bit   prio = 1'b0;
    int   rst_cycle = -1;
    bit   rst_req = 1'b1;
    bit   no_gap = 1'b1;
    bit   acc[2];
    bit   cur_abort[2];

    txn_t pend0[$];
    txn_t pend1[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [1:0]     eg;
        logic [A+L-1:0] e;
        logic [A-1:0]   a;
        logic [L-1:0]   d;
        bit             exp_busy;
        int             w;
        int             n;
        eg = 2'b00;
        if (!rst && cyc >= free_at) begin
            if (req_valid == 2'b11) eg = prio ? 2'b10 : 2'b01;
            else                    eg = req_valid;
        end
        check("req_ready", 64'(req_ready), 64'(eg));
        exp_busy = (cyc >= busy_from) && (cyc < free_at);
        check("busy", 64'(busy), 64'(exp_busy));
        check("idle_state", 64'(state == IDLE), 64'(!exp_busy));

        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            e = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            check("mem_we", 64'(mem_we), 64'd1);
            check("mem_address", 64'(mem_address), 64'(e[A+L-1:L]));
            check("mem_data", 64'(mem_data), 64'(e[L-1:0]));
        end else begin
            check("mem_we_idle", 64'(mem_we), 64'd0);
            check("mem_address_idle", 64'(mem_address), 64'd0);
            check("mem_data_idle", 64'(mem_data), 64'd0);
        end

        if (done_cyc_q.size() > 0 && done_cyc_q[0] == cyc) begin
            void'(done_cyc_q.pop_front());
            check("done", 64'(done), 64'd1);
            check("done_id", 64'(done_id), 64'(done_id_q.pop_front()));
        end else begin
            check("done_idle", 64'(done), 64'd0);
        end

        if (rst) begin
            // the in-flight request is abandoned at the end of this cycle
            while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > cyc) begin
                void'(exp_cyc_q.pop_back());
                void'(exp_q.pop_back());
            end
            while (done_cyc_q.size() > 0 && done_cyc_q[$] > cyc) begin
                void'(done_cyc_q.pop_back());
                void'(done_id_q.pop_back());
            end
            free_at   = cyc + 1;
            busy_from = cyc + 1;
            prio      = 1'b0;
        end else if (eg != 2'b00) begin
            w = eg[1] ? 1 : 0;
            n = req_op_type[w] ? I : 1;
            for (int k = 0; k < n; k++) begin
                a = req_base_address[w] + A'(k);
                d = req_op_type[w] ? req_vector_data[w][k] : req_scalar_data[w];
                exp_q.push_back({a, d});
                exp_cyc_q.push_back(cyc + 1 + k);
            end
            done_cyc_q.push_back(cyc + n + 1);
            done_id_q.push_back(w[0]);
            busy_from = cyc + 1;
            free_at   = cyc + n + 2;
            prio      = (w == 0);
            acc[w]    = 1'b1;
            if (cur_abort[w]) rst_cycle = cyc + 7;
        end
    endtask

    // ---------------- driver ----------------
    task automatic scramble(input int r);
        req_op_type[r]      = 1'($urandom);
        req_base_address[r] = A'($urandom);
        req_scalar_data[r]  = $urandom;
        for (int k = 0; k < I; k++) req_vector_data[r][k] = $urandom;
    endtask

    task automatic present(input int r, input txn_t t);
        req_valid[r]        = 1'b1;
        req_op_type[r]      = t.op;
        req_base_address[r] = t.base;
        req_vector_data[r]  = t.vec;
        req_scalar_data[r]  = t.sc;
        cur_abort[r]        = t.abort;
    endtask

    task automatic drive();
        txn_t t;
        rst = rst_req || (cyc == rst_cycle);
        for (int r = 0; r < 2; r++) begin
            if (acc[r]) begin
                acc[r] = 1'b0;
                req_valid[r] = 1'b0;
                scramble(r);
            end
            if (!req_valid[r] && (no_gap || $urandom_range(0, 2) == 0)) begin
                if (r == 0 && pend0.size() > 0) begin
                    t = pend0.pop_front();
                    present(0, t);
                end else if (r == 1 && pend1.size() > 0) begin
                    t = pend1.pop_front();
                    present(1, t);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (!(pend0.size() == 0 && pend1.size() == 0 && req_valid == 2'b00 &&
                 cyc >= free_at && cyc > rst_cycle)) begin
            if (n >= budget) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout: still busy after %0d cycles, required idle", n);
                return;
            end
            step();
            n++;
        end
        step();
    endtask

    function automatic txn_t mk_rand(input bit op, input logic [A-1:0] base);
        txn_t t;
        t.op    = op;
        t.abort = 1'b0;
        t.base  = base;
        t.sc    = $urandom;
        for (int k = 0; k < I; k++) t.vec[k] = $urandom;
        return t;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        txn_t t;
        req_valid = 2'b00;
        scramble(0);
        scramble(1);
        acc[0] = 0; acc[1] = 0;
        cur_abort[0] = 0; cur_abort[1] = 0;

        // reset state
        repeat (3) step();
        rst_req = 1'b0;

        // scalar from requester 0
        t = mk_rand(1'b0, A'(5));
        t.sc = 32'hDEADBEEF;
        pend0.push_back(t);
        run_idle(100);

        // vector from requester 1, item k = k+1
        t = mk_rand(1'b1, A'(100));
        for (int k = 0; k < I; k++) t.vec[k] = L'(k + 1);
        pend1.push_back(t);
        run_idle(100);

        // both requesters valid straight out of reset
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        pend0.push_back(mk_rand(1'b0, A'($urandom)));
        pend1.push_back(mk_rand(1'b1, A'($urandom)));
        pend0.push_back(mk_rand(1'b0, A'($urandom)));
        run_idle(200);

        // address wrap at the top of memory
        pend0.push_back(mk_rand(1'b1, A'(1020)));
        run_idle(100);

        // reset at the 7th write of a vector, then a normal request
        t = mk_rand(1'b1, A'($urandom));
        t.abort = 1'b1;
        pend1.push_back(t);
        pend0.push_back(mk_rand(1'b0, A'($urandom)));
        run_idle(200);
        pend1.push_back(mk_rand(1'b1, A'($urandom)));
        run_idle(100);

        // randomized traffic
        no_gap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            t = mk_rand(1'($urandom), A'($urandom));
            if ($urandom_range(0, 1) == 0) pend0.push_back(t);
            else                           pend1.push_back(t);
        end
        run_idle(20000);

        if (exp_q.size() != 0 || done_cyc_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover: %0d writes and %0d done pulses never seen, required 0",
                     exp_q.size(), done_cyc_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/write_scheduler.md
# write_scheduler

Sequencing and arbitration controller for the vector data-memory write path. Two requesters share one memory write port: requester 0 is the execute-stage store unit, requester 1 is the program/data loader. Each request is a scalar store (one word) or a vector store (I consecutive words from a base address). The block grants requesters round-robin, captures the request, and drives one memory write per cycle. It then pulses a completion flag tagged with the requester id.

## Interface
- I, 20, items per vector
- L, 32, item width in bits
- A, 10, address width in bits
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; at most one bit set
- req_op_type  in  2  per requester: 1 = vector store, 0 = scalar store
- req_base_address  in  2 x A  per-requester base address
- req_vector_data  in  2 x I x L  per-requester vector operand; item k at index k
- req_scalar_data  in  2 x L  per-requester scalar operand
- mem_we  out  1  memory write enable
- mem_address  out  A  memory write address
- mem_data  out  L  memory write data
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester whose request completed; valid only while done=1

## Operation
- States: IDLE, WRITE, DONE.
- **IDLE:**
  - Arbitration is combinational over req_valid.
  - If exactly one bit is valid, that requester wins.
  - If both are valid, the requester named by priority pointer prio wins.
  - req_ready[winner]=1.
  - On valid&ready, the block:
    - captures op_type, base address, vector data and scalar data into internal registers;
    - stores the winner id;
    - sets index=0 and prio=~winner;
    - moves to WRITE.
- **WRITE:**
  - mem_we=1.
  - mem_address = captured base + index, truncated to A bits (wraps modulo 2^A, e.g. base 1020 with I=20 yields 1020..1023, then 0..15).
  - mem_data = captured vector item[index] if vector, else captured scalar.
  - Scalar: one WRITE cycle, then DONE.
  - Vector: index increments each cycle; at index==I-1, next state is DONE.
- **DONE:**
  - done=1 and done_id=stored id.
  - Next state is IDLE unconditionally.
- Requester inputs are ignored outside the accept cycle. Changes after acceptance do not affect writes in flight.
- The index register is wide enough for I-1 (clog2(I) bits minimum). The address sum is computed at A bits.

## Timing
- Reset values:
  - state=IDLE, prio=0, index=0;
  - mem_we=0, mem_address=0, mem_data=0;
  - busy=0, done=0, done_id=0, req_ready=0.
- req_ready is asserted only in IDLE. A requester holds req_valid and its operands stable until it sees ready.
- With acceptance at cycle T:
  - first write is at T+1;
  - last write is at T+1 (scalar) or T+I (vector);
  - done is at T+2 (scalar) or T+I+1 (vector);
  - the next acceptance is no earlier than T+3 (scalar) or T+I+2 (vector).
- mem_address, mem_data and mem_we are registered or decoded from registered state only; no combinational path from req_* to mem_*.
- mem_address and mem_data are 0 when mem_we=0.
- A simultaneous request from both requesters is resolved by prio. The loser keeps valid and is granted at the next IDLE.
- Reset during WRITE or DONE:
  - the next cycle is IDLE with reset values;
  - no further writes occur and no done pulse is issued for the aborted request.
- Reset overrides a same-cycle acceptance; nothing is captured.

## Structure
- Shared package write_sched_pkg holds:
  - the state enum (IDLE, WRITE, DONE);
  - default parameter constants I_DEF=20, L_DEF=32, A_DEF=10;
  - requester-id typedef (1 bit).
- Sub-module rr_arbiter2: 2-way round-robin arbiter with inputs req[1:0] and prio, and output grant[1:0] (one-hot or zero). It is purely combinational; prio update stays in write_scheduler.
- Capture registers, index counter, FSM and output decode live in write_scheduler.

## Test plan
- Reset, then scalar from requester 0 (base 5, data 0xDEADBEEF) -> exactly one write, addr 5 data 0xDEADBEEF; done with done_id=0 one cycle after the write; busy high for 2 cycles.
- Vector from requester 1 (base 100, item k = k+1) -> 20 consecutive writes, addr 100..119 data 1..20; done and done_id=1 at T+21.
- Both requesters valid from reset -> requester 0 served first, requester 1 second, then requester 0 again; verifies prio alternation and the loser holding valid.
- Vector at base 1020 -> addresses 1020,1021,1022,1023,0,...,15; no out-of-range address.
- Operands changed on the cycle after acceptance -> written data matches the originally captured values.
- rst asserted at the 7th write of a vector -> mem_we=0 from the next cycle, no done pulse, state IDLE, and a new request is accepted normally afterward.
